// File: rtl/query_engine_scheduler.sv
// Round-robin scheduler that hands one query job at a time to a free
// Smith-Waterman engine and streams the job's query blocks to that engine only.
module query_engine_scheduler #(
  parameter int NUM_PES     = 64,
  parameter int NUM_ENGINES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [24:0]            ref_length_in,
  input  logic [24:0]            ref_addr_in,
  input  logic [15:0]            num_query_blocks_in,
  input  logic                   query_info_valid_in,
  output logic                   query_info_rdy_out,
  input  logic [NUM_PES*2-1:0]   query_seq_block_in,
  input  logic                   query_seq_block_valid_in,
  output logic                   query_seq_block_rdy_out,
  output logic [24:0]            eng_ref_length_out,
  output logic [24:0]            eng_ref_addr_out,
  output logic [15:0]            eng_num_query_blocks_out,
  output logic [NUM_PES*2-1:0]   eng_query_seq_block_out,
  output logic [NUM_ENGINES-1:0] eng_query_info_valid_out,
  input  logic [NUM_ENGINES-1:0] eng_query_info_rdy_in,
  output logic [NUM_ENGINES-1:0] eng_query_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0] eng_query_seq_block_rdy_in,
  input  logic [NUM_ENGINES-1:0] eng_done_in,
  output logic [NUM_ENGINES-1:0] eng_busy_out,
  output logic [3:0]             grant_idx_out
);

  typedef enum logic [1:0] {IDLE, INFO, BLOCKS} state_t;

  state_t                 state;
  logic [3:0]             sel;
  logic [3:0]             ptr;
  logic [NUM_ENGINES-1:0] busy;
  logic [NUM_ENGINES-1:0] busy_next;
  logic [15:0]            num_blocks;
  logic [15:0]            block_cnt;

  // Zero-extended copies so a 4-bit engine index can select any bit cleanly.
  logic [15:0]            busy_ext;
  logic [15:0]            info_rdy_ext;
  logic [15:0]            block_rdy_ext;
  logic [NUM_ENGINES-1:0] sel_onehot;

  logic [4:0]             cand;
  logic [3:0]             next_free;
  logic                   free_found;
  logic                   info_hs;
  logic                   block_hs;

  assign busy_ext      = 16'(busy);
  assign info_rdy_ext  = 16'(eng_query_info_rdy_in);
  assign block_rdy_ext = 16'(eng_query_seq_block_rdy_in);
  assign sel_onehot    = NUM_ENGINES'(1) << sel;

  assign eng_ref_length_out       = ref_length_in;
  assign eng_ref_addr_out         = ref_addr_in;
  assign eng_num_query_blocks_out = num_query_blocks_in;
  assign eng_query_seq_block_out  = query_seq_block_in;

  // First free engine searching upward from the last grant, wrapping.
  always_comb begin
    next_free  = '0;
    free_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      cand = 5'(ptr) + 5'(k);
      if (cand >= 5'(NUM_ENGINES)) cand = cand - 5'(NUM_ENGINES);
      if (!free_found && !busy_ext[cand[3:0]]) begin
        free_found = 1'b1;
        next_free  = cand[3:0];
      end
    end
  end

  // NOTE: rst is synchronous, so the state register may still read INFO or
  // BLOCKS during the reset cycle; the handshake outputs are gated by rst.
  always_comb begin
    eng_query_info_valid_out      = '0;
    eng_query_seq_block_valid_out = '0;
    query_info_rdy_out            = 1'b0;
    query_seq_block_rdy_out       = 1'b0;
    if (!rst && state == INFO) begin
      eng_query_info_valid_out = query_info_valid_in ? sel_onehot : '0;
      query_info_rdy_out       = info_rdy_ext[sel];
    end
    if (!rst && state == BLOCKS) begin
      eng_query_seq_block_valid_out = query_seq_block_valid_in ? sel_onehot : '0;
      query_seq_block_rdy_out       = block_rdy_ext[sel];
    end
  end

  assign info_hs  = query_info_valid_in && query_info_rdy_out;
  assign block_hs = query_seq_block_valid_in && query_seq_block_rdy_out;

  // A grant's set is applied after the done clear, so the set wins a collision.
  assign busy_next = (busy & ~eng_done_in) | (info_hs ? sel_onehot : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= '0;
      sel        <= '0;
      ptr        <= 4'(NUM_ENGINES - 1);
      num_blocks <= '0;
      block_cnt  <= '0;
    end else begin
      busy <= busy_next;
      case (state)
        IDLE: begin
          if (query_info_valid_in && free_found) begin
            sel   <= next_free;
            state <= INFO;
          end
        end
        INFO: begin
          if (info_hs) begin
            ptr        <= sel;
            num_blocks <= num_query_blocks_in;
            block_cnt  <= '0;
            state      <= (num_query_blocks_in == 16'd0) ? IDLE : BLOCKS;
          end
        end
        BLOCKS: begin
          if (block_hs) begin
            block_cnt <= block_cnt + 16'd1;
            if (block_cnt + 16'd1 == num_blocks) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eng_busy_out  = busy;
  assign grant_idx_out = sel;

endmodule

// File: tb/tb_query_engine_scheduler.sv
// Self-checking bench for query_engine_scheduler: table of scripted jobs,
// hand-written corner sequences, then randomized jobs against a grant model.
module tb_query_engine_scheduler;

  localparam int NP = 64;
  localparam int NE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [24:0]     ref_length_in;
  logic [24:0]     ref_addr_in;
  logic [15:0]     num_query_blocks_in;
  logic            query_info_valid_in;
  logic            query_info_rdy_out;
  logic [NP*2-1:0] query_seq_block_in;
  logic            query_seq_block_valid_in;
  logic            query_seq_block_rdy_out;
  logic [24:0]     eng_ref_length_out;
  logic [24:0]     eng_ref_addr_out;
  logic [15:0]     eng_num_query_blocks_out;
  logic [NP*2-1:0] eng_query_seq_block_out;
  logic [NE-1:0]   eng_query_info_valid_out;
  logic [NE-1:0]   eng_query_info_rdy_in;
  logic [NE-1:0]   eng_query_seq_block_valid_out;
  logic [NE-1:0]   eng_query_seq_block_rdy_in;
  logic [NE-1:0]   eng_done_in;
  logic [NE-1:0]   eng_busy_out;
  logic [3:0]      grant_idx_out;

  query_engine_scheduler #(.NUM_PES(NP), .NUM_ENGINES(NE)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .ref_length_in                 (ref_length_in),
    .ref_addr_in                   (ref_addr_in),
    .num_query_blocks_in           (num_query_blocks_in),
    .query_info_valid_in           (query_info_valid_in),
    .query_info_rdy_out            (query_info_rdy_out),
    .query_seq_block_in            (query_seq_block_in),
    .query_seq_block_valid_in      (query_seq_block_valid_in),
    .query_seq_block_rdy_out       (query_seq_block_rdy_out),
    .eng_ref_length_out            (eng_ref_length_out),
    .eng_ref_addr_out              (eng_ref_addr_out),
    .eng_num_query_blocks_out      (eng_num_query_blocks_out),
    .eng_query_seq_block_out       (eng_query_seq_block_out),
    .eng_query_info_valid_out      (eng_query_info_valid_out),
    .eng_query_info_rdy_in         (eng_query_info_rdy_in),
    .eng_query_seq_block_valid_out (eng_query_seq_block_valid_out),
    .eng_query_seq_block_rdy_in    (eng_query_seq_block_rdy_in),
    .eng_done_in                   (eng_done_in),
    .eng_busy_out                  (eng_busy_out),
    .grant_idx_out                 (grant_idx_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NE-1:0] done_before;
    int            num;
    int            exp_eng;
    logic [NE-1:0] exp_busy;
  } job_vec_t;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [NE-1:0] busy_m;
  int            ptr_m;
  job_vec_t      tbl[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference grant rule: first free engine after the last grant, wrapping.
  function automatic int expect_grant();
    for (int k = 1; k <= NE; k++) begin
      if (!busy_m[(ptr_m + k) % NE]) return (ptr_m + k) % NE;
    end
    return -1;
  endfunction

  function automatic logic [NE-1:0] rand_mask(input int pct);
    logic [NE-1:0] m;
    for (int i = 0; i < NE; i++) m[i] = ($urandom_range(99) < pct);
    return m;
  endfunction

  task automatic idle_inputs();
    query_info_valid_in        = 1'b0;
    query_seq_block_valid_in   = 1'b0;
    eng_query_info_rdy_in      = '0;
    eng_query_seq_block_rdy_in = '0;
    eng_done_in                = '0;
  endtask

  task automatic pulse_done(input logic [NE-1:0] mask);
    eng_done_in = mask;
    @(negedge clk);
    eng_done_in = '0;
    busy_m      = busy_m & ~mask;
  endtask

  // Runs one job from a negedge; returns at a negedge. done_hs is pulsed in
  // the info handshake cycle, bp_at stalls the engine for 5 cycles after that
  // many blocks, abort_at returns mid-job without closing it.
  task automatic run_job(input int num, input int pct, input int exp_eng,
                         input logic [NE-1:0] done_hs, input int bp_at, input int abort_at);
    logic [NE-1:0] eh;
    int budget, hs, first_seen, bp_left, bp_cycles;
    bit got, err_oh, err_blk;
    eh = NE'(1) << exp_eng;
    ref_length_in       = 25'($urandom);
    ref_addr_in         = 25'($urandom);
    num_query_blocks_in = 16'(num);
    query_info_valid_in = 1'b1;
    got = 0; err_oh = 0; budget = 0; first_seen = -1;
    while (!got && budget < 200) begin
      eng_done_in           = '0;
      eng_query_info_rdy_in = rand_mask(pct);
      #1;
      if (eng_query_info_valid_out !== '0 && eng_query_info_valid_out !== eh) err_oh = 1;
      if (query_info_rdy_out !== ((eng_query_info_valid_out != '0) & eng_query_info_rdy_in[exp_eng]))
        err_oh = 1;
      if (eng_query_info_valid_out == eh && first_seen < 0) first_seen = budget;
      got = (eng_query_info_valid_out == eh) && query_info_rdy_out;
      if (got) eng_done_in = done_hs;
      @(negedge clk);
      budget++;
    end
    eng_done_in = '0;
    check("info_handshake", 128'(got), 128'(1));
    check("info_onehot", 128'(err_oh), 128'(0));
    check("info_latency", 128'(first_seen), 128'(1));
    check("broadcast", {eng_ref_length_out, eng_ref_addr_out, eng_num_query_blocks_out},
          {ref_length_in, ref_addr_in, num_query_blocks_in});
    query_info_valid_in   = 1'b0;
    eng_query_info_rdy_in = '0;
    busy_m = (busy_m & ~done_hs) | eh;
    ptr_m  = exp_eng;

    hs = 0; budget = 0; err_blk = 0; bp_cycles = 0;
    bp_left = (bp_at >= 0) ? 5 : 0;
    while (hs < num && hs != abort_at && budget < 500) begin
      query_seq_block_in = {$urandom, $urandom, $urandom, $urandom};
      if (hs == bp_at && bp_left > 0) begin
        query_seq_block_valid_in   = 1'b1;
        eng_query_seq_block_rdy_in = '0;
        bp_left--;
        bp_cycles++;
      end else begin
        query_seq_block_valid_in   = ($urandom_range(99) < pct);
        eng_query_seq_block_rdy_in = rand_mask(pct);
      end
      #1;
      if (eng_query_seq_block_valid_out !== (query_seq_block_valid_in ? eh : '0)) err_blk = 1;
      if (query_seq_block_rdy_out !== eng_query_seq_block_rdy_in[exp_eng]) err_blk = 1;
      if (eng_query_seq_block_out !== query_seq_block_in) err_blk = 1;
      if (query_seq_block_valid_in && query_seq_block_rdy_out) hs++;
      @(negedge clk);
      budget++;
    end
    if (abort_at >= 0) return;
    check("block_count", 128'(hs), 128'(num));
    check("block_stream", 128'(err_blk), 128'(0));
    if (bp_at >= 0) check("backpressure_cycles", 128'(bp_cycles), 128'(5));

    // Job is over: a willing engine and valid data must not see a block.
    query_seq_block_valid_in   = 1'b1;
    eng_query_seq_block_rdy_in = '1;
    #1;
    check("end_of_job", {eng_query_seq_block_valid_out, query_seq_block_rdy_out}, '0);
    check("busy_flags", 128'(eng_busy_out), 128'(busy_m));
    check("grant_idx", 128'(grant_idx_out), 128'(exp_eng));
    @(negedge clk);
    query_seq_block_valid_in   = 1'b0;
    eng_query_seq_block_rdy_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    query_info_valid_in        = 1'b1;
    query_seq_block_valid_in   = 1'b1;
    eng_query_info_rdy_in      = '1;
    eng_query_seq_block_rdy_in = '1;
    eng_done_in                = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", {eng_query_info_valid_out, eng_query_seq_block_valid_out,
                            query_info_rdy_out, query_seq_block_rdy_out}, '0);
    check("reset_state", {eng_busy_out, grant_idx_out}, '0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    busy_m = '0;
    ptr_m  = NE - 1;
  endtask

  initial begin
    bit stall_err;
    logic [NE-1:0] m;
    int e;

    tbl[0] = '{4'b0000, 3, 0, 4'b0001};
    tbl[1] = '{4'b0000, 1, 1, 4'b0011};
    tbl[2] = '{4'b0000, 1, 2, 4'b0111};
    tbl[3] = '{4'b0000, 1, 3, 4'b1111};
    tbl[4] = '{4'b0100, 1, 2, 4'b1111};
    tbl[5] = '{4'b0011, 0, 0, 4'b1101};
    tbl[6] = '{4'b0000, 2, 1, 4'b1111};

    ref_length_in       = '0;
    ref_addr_in         = '0;
    num_query_blocks_in = '0;
    query_seq_block_in  = '0;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].done_before != '0) pulse_done(tbl[i].done_before);
      run_job(tbl[i].num, 80, tbl[i].exp_eng, '0, -1, -1);
      check($sformatf("tbl%0d_busy", i), 128'(eng_busy_out), 128'(tbl[i].exp_busy));
    end

    // All engines busy: the job waits until engine 2 reports done.
    query_info_valid_in   = 1'b1;
    eng_query_info_rdy_in = '1;
    stall_err = 0;
    repeat (6) begin
      #1;
      if (query_info_rdy_out !== 1'b0 || eng_query_info_valid_out !== '0) stall_err = 1;
      @(negedge clk);
    end
    check("stall_all_busy", 128'(stall_err), 128'(0));
    pulse_done(4'b0100);
    run_job(1, 100, 2, '0, -1, -1);

    // Done for engine 1 in the very cycle it is granted: set wins.
    pulse_done(4'b0010);
    run_job(1, 100, 1, 4'b0010, -1, -1);
    check("done_grant_collision", 128'(eng_busy_out[1]), 128'(1));

    // Engine backpressure for 5 cycles after 2 of 4 blocks.
    pulse_done(4'b1000);
    run_job(4, 100, 3, '0, 2, -1);

    // Reset after 2 of 5 blocks abandons the job.
    pulse_done(4'b0100);
    run_job(5, 100, 2, '0, -1, 2);
    rst = 1'b1;
    query_seq_block_valid_in   = 1'b1;
    eng_query_seq_block_rdy_in = '1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midjob_reset_busy", 128'(eng_busy_out), 128'(0));
    check("midjob_reset_valids", {eng_query_info_valid_out, eng_query_seq_block_valid_out,
                                  query_info_rdy_out, query_seq_block_rdy_out}, '0);
    @(negedge clk);
    idle_inputs();
    busy_m = '0;
    ptr_m  = NE - 1;
    run_job(2, 100, 0, '0, -1, -1);

    // Randomized jobs against the grant model.
    for (int j = 0; j < 40; j++) begin
      m = NE'($urandom);
      if ((busy_m & ~m) == '1) m[$urandom_range(NE - 1)] = 1'b1;
      if (m != '0) pulse_done(m);
      e = expect_grant();
      run_job(int'($urandom_range(5)), 70, e, '0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/query_engine_scheduler.md
Name: query_engine_scheduler

Overview:
- Sits between the PCIe stream input handler and an array of NUM_ENGINES Smith-Waterman engines.
- Accepts one query job (query info, then num_query_blocks query sequence blocks) and grants it to a free engine, chosen round-robin.
- Streams that job's blocks to the granted engine only.
- Tracks which engines are busy until each engine reports done.

Parameters:
- NUM_PES, 64, PEs per engine; the query block is NUM_PES*2 bits wide.
- NUM_ENGINES, 4, number of engines scheduled; legal range 2..16.

Ports:
- clk  in  1  engine clock
- rst  in  1  reset
- ref_length_in  in  25  reference length of the incoming job
- ref_addr_in  in  25  reference address
- num_query_blocks_in  in  16  number of query blocks in the job
- query_info_valid_in  in  1  upstream info valid
- query_info_rdy_out  out  1  info accepted by the granted engine
- query_seq_block_in  in  NUM_PES*2  query block
- query_seq_block_valid_in  in  1  upstream block valid
- query_seq_block_rdy_out  out  1  block accepted
- eng_ref_length_out  out  25  broadcast to all engines
- eng_ref_addr_out  out  25  broadcast
- eng_num_query_blocks_out  out  16  broadcast
- eng_query_seq_block_out  out  NUM_PES*2  broadcast
- eng_query_info_valid_out  out  NUM_ENGINES  one-hot info valid
- eng_query_info_rdy_in  in  NUM_ENGINES  per-engine info ready
- eng_query_seq_block_valid_out  out  NUM_ENGINES  one-hot block valid
- eng_query_seq_block_rdy_in  in  NUM_ENGINES  per-engine block ready
- eng_done_in  in  NUM_ENGINES  one-cycle pulse when an engine finishes its job
- eng_busy_out  out  NUM_ENGINES  registered busy flags
- grant_idx_out  out  4  index of the current or last granted engine

Behaviour:
- Reset and interface basics:
  - rst is synchronous, active-high. clk is the only clock.
  - On reset: state=IDLE; eng_busy_out=0; grant_idx_out=0; last-grant pointer=NUM_ENGINES-1, so the first grant goes to engine 0; block counter=0.
  - During reset, all valid and rdy outputs are 0.
  - Broadcast data outputs are pure wires from the inputs.
- State IDLE:
  - All valid and rdy outputs are 0.
  - If query_info_valid_in=1 and at least one busy flag is 0, register sel = the first free engine searching upward from pointer+1 mod NUM_ENGINES, then go to INFO.
  - If all engines are busy, stay in IDLE.
- State INFO:
  - eng_query_info_valid_out[sel] = query_info_valid_in; query_info_rdy_out = eng_query_info_rdy_in[sel]. Both are combinational, with zero-cycle pass-through.
  - On a handshake (valid & rdy):
    - Set busy[sel] and update pointer=sel.
    - Latch num_query_blocks_in into a counter register and clear the block counter.
    - If num_query_blocks_in=0, go to IDLE; otherwise go to BLOCKS.
- State BLOCKS:
  - eng_query_seq_block_valid_out[sel] = query_seq_block_valid_in; query_seq_block_rdy_out = eng_query_seq_block_rdy_in[sel].
  - Increment the counter on each handshake.
  - The handshake that brings the count equal to the latched number is the last one; go to IDLE on the next edge.
  - Counter arithmetic is 16-bit; a count of 65535 is legal and no wrap occurs.
- Busy flags:
  - busy[i] clears on eng_done_in[i] in any state.
  - If a done and a grant set hit the same engine in the same cycle, the set wins.
  - A done pulse for an engine that is not busy is ignored.
  - Done pulses during BLOCKS only affect later grants.
- Invariants:
  - At most one bit is ever set in the one-hot valid vectors.
  - Non-selected engines always see valid=0.
- Latency:
  - Info valid in IDLE to eng info valid in INFO: 1 cycle.
  - Last block accepted to next eligible grant: 1 cycle (IDLE), so a new job reaches INFO 2 cycles after the last block.
- Reset mid-job: abandons the job, clears all busy flags, and returns to IDLE with no output pulse. Upstream data is not flushed.

Test Plan:
- Reset, then a job with num=3 and all engines ready → grant to engine 0; eng_query_info_valid_out=0001; exactly 3 blocks appear on eng_query_seq_block_valid_out bit 0; eng_busy_out=0001; FSM back in IDLE 1 cycle after the 3rd handshake.
- Four back-to-back jobs (num=1 each) with no done pulses → grants 0,1,2,3; eng_busy_out=1111. A fifth job stalls with query_info_rdy_out=0 until eng_done_in[2] pulses, then it is granted to engine 2.
- Backpressure: eng_query_seq_block_rdy_in[sel] held low for 5 cycles mid-job → query_seq_block_rdy_out=0 for those cycles and the counter holds; the job still completes with exactly num handshakes.
- Job with num=0 → info handshake, busy set, return to IDLE with no block valid ever raised. Also: eng_done_in[1] pulsed in the same cycle engine 1 is granted → busy[1]=1.
- Assert rst during BLOCKS after 2 of 5 blocks → next cycle: eng_busy_out=0, all valids 0, IDLE; the next job is granted to engine 0.
